// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider controller and its iterative core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, default widths, and the latched-operation record
// that div_ctrl keeps for the sign fix-up and divide-by-zero bypass.
package div_ctrl_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = 6;
  // EX -> divider request bus: signed flag, is_mod flag, two operands.
  localparam int DIV_BUS_W  = 2 + 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Per-operation attributes captured on the accepting edge.
  typedef struct packed {
    logic is_signed;
    logic is_mod;
    logic s1;        // sign bit of dividend
    logic s2;        // sign bit of divisor
    logic divzero;   // divisor was zero
  } div_op_t;

endpackage

// File: rtl/div_core_iter.sv
// Unsigned restoring shift-subtract divider core, one quotient bit per step.
// Latency: DATA_W steps after load; outputs are valid once the last step has registered.
// Backpressure: none; sequencing (load/step/clear) is entirely owned by div_ctrl.
//
// Ports: clk, resetn (async active-low); load latches dividend/divisor and zeroes the
// partial remainder; step performs one iteration; clear discards all state.
// quotient/remainder are the register contents.
module div_core_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;
  logic [DATA_W-1:0] dvs_q;

  // The shifted partial remainder can reach 2*divisor-1, so it needs DATA_W+1 bits;
  // one more bit on the difference captures the borrow.
  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;
  logic              ge;
  logic              diff_unused;

  assign shifted     = {rem_q, quo_q[DATA_W-1]};
  assign diff        = {1'b0, shifted} - {2'b00, dvs_q};
  assign ge          = ~diff[DATA_W+1];
  // When ge is set the difference is below the divisor, so bit DATA_W is always zero.
  assign diff_unused = diff[DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (clear) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ge};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/div_ctrl.sv
// Sequencing controller for the EX-stage divider (div.w/mod.w/div.wu/mod.wu).
// Latency: res_valid rises DATA_W+1 edges after the accepting edge, for any operands.
// Backpressure: result held in DONE until res_ready; no new request accepted until back in IDLE.
//
// Ports: clk, resetn (async active-low); req_valid/req_ready with req_signed, req_is_mod,
// req_src1 (dividend), req_src2 (divisor); cancel flushes everything; res_valid/res_ready
// with res_data; busy is high whenever the FSM is not idle.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic              req_is_mod,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic              cancel,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  div_op_t           op_q;
  logic [DATA_W-1:0] abs1_q;
  logic              res_valid_q;
  logic [DATA_W-1:0] res_data_q;

  logic              accept;
  logic              step;
  logic              finish;

  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] core_quo;
  logic [DATA_W-1:0] core_rem;
  logic [DATA_W-1:0] raw_src1;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] res_next;

  // Operand magnitudes; 0x80000000 maps to itself, which keeps the overflow case
  // correct modulo 2^DATA_W without special handling.
  assign abs1 = (req_signed && req_src1[DATA_W-1]) ? (-req_src1) : req_src1;
  assign abs2 = (req_signed && req_src2[DATA_W-1]) ? (-req_src2) : req_src2;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        req_ready = !cancel;
        if (req_valid && !cancel) begin
          accept  = 1'b1;
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        // DATA_W iteration cycles, then one cycle to register the fixed-up result.
        if (cnt_q != '0) begin
          step = 1'b1;
        end else begin
          finish  = 1'b1;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (res_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
    // Flush beats everything else in the same cycle.
    if (cancel) begin
      state_d = DIV_IDLE;
      step    = 1'b0;
      finish  = 1'b0;
    end
  end

  // ---------------- Operation latch and counter ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      abs1_q <= '0;
    end else if (accept) begin
      op_q.is_signed <= req_signed;
      op_q.is_mod    <= req_is_mod;
      op_q.s1        <= req_src1[DATA_W-1];
      op_q.s2        <= req_src2[DATA_W-1];
      op_q.divzero   <= (req_src2 == '0);
      abs1_q         <= abs1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (cancel) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= CNT_W'(DATA_W);
    end else if (step) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // ---------------- Iterative core ----------------
  div_core_iter #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk       (clk),
    .resetn    (resetn),
    .load      (accept),
    .step      (step),
    .clear     (cancel),
    .dividend  (abs1),
    .divisor   (abs2),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  // ---------------- Sign fix-up and divide-by-zero bypass ----------------
  always_comb begin
    // Rebuild the original dividend from its magnitude for the divide-by-zero remainder.
    raw_src1 = (op_q.is_signed && op_q.s1) ? (-abs1_q) : abs1_q;
    quo_fix  = (op_q.is_signed && (op_q.s1 != op_q.s2)) ? (-core_quo) : core_quo;
    rem_fix  = (op_q.is_signed && op_q.s1) ? (-core_rem) : core_rem;
    if (op_q.divzero) begin
      res_next = op_q.is_mod ? raw_src1 : '1;
    end else begin
      res_next = op_q.is_mod ? rem_fix : quo_fix;
    end
  end

  // ---------------- Result register ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_valid_q <= 1'b0;
    end else if (cancel) begin
      res_valid_q <= 1'b0;
    end else if (finish) begin
      res_valid_q <= 1'b1;
    end else if ((state_q == DIV_DONE) && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_data_q <= '0;
    end else if (finish) begin
      res_data_q <= res_next;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != DIV_IDLE);

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: vector table of divides plus hand sequences for
// cancel, result hold, and asynchronous reset in the middle of an operation.
module tb_div_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic        req_is_mod;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        cancel;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int n_cmp;
  int n_err;

  div_ctrl #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .req_is_mod (req_is_mod),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .cancel     (cancel),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accepting edge.
  // Operands are scrambled afterwards to show they are only sampled on acceptance.
  task automatic start_req(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
    req_signed = sgn;
    req_is_mod = md;
    req_src1   = a;
    req_src2   = b;
    req_valid  = 1'b1;
    #1;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_signed = ~sgn;
    req_is_mod = ~md;
    req_src1   = $urandom;
    req_src2   = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    chk("res_valid_after_consume", {31'd0, res_valid}, 32'd0);
  endtask

  initial begin
    int   lat;
    logic seen;

    n_cmp = 0;
    n_err = 0;

    //             sgn   md    dividend       divisor        expected
    vecs[0]  = '{1'b0, 1'b0, 32'd100,       32'd7,         32'h0000000E};
    vecs[1]  = '{1'b0, 1'b1, 32'd100,       32'd7,         32'h00000002};
    vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 1'b0, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD};
    vecs[5]  = '{1'b1, 1'b1, 32'd7,         32'hFFFFFFFE,  32'h00000001};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'h00000003};
    vecs[7]  = '{1'b1, 1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h80000000};
    vecs[9]  = '{1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h00000000};
    vecs[10] = '{1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000};
    vecs[11] = '{1'b0, 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000};
    vecs[12] = '{1'b1, 1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF};
    vecs[13] = '{1'b1, 1'b1, 32'h12345678,  32'd0,         32'h12345678};
    vecs[14] = '{1'b0, 1'b0, 32'h12345678,  32'd0,         32'hFFFFFFFF};
    vecs[15] = '{1'b0, 1'b1, 32'h12345678,  32'd0,         32'h12345678};

    resetn     = 1'b0;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_is_mod = 1'b0;
    req_src1   = '0;
    req_src2   = '0;
    cancel     = 1'b0;
    res_ready  = 1'b0;

    // Reset state
    #3;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_res_data", res_data, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      start_req(vecs[i].sgn, vecs[i].md, vecs[i].a, vecs[i].b);
      wait_result(lat);
      chk($sformatf("latency_v%0d", i), lat, 32'd33);
      chk($sformatf("result_v%0d", i), res_data, vecs[i].exp);
      consume();
    end

    // Cancel during the tenth RUN cycle
    start_req(1'b0, 1'b0, 32'd1000, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    cancel = 1'b1;
    #1;
    chk("cancel_req_ready_run", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    #1;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_res_valid", {31'd0, res_valid}, 32'd0);
    chk("cancel_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | res_valid;
    end
    chk("cancel_no_result", {31'd0, seen}, 32'd0);
    start_req(1'b0, 1'b0, 32'd9, 32'd3);
    wait_result(lat);
    chk("after_cancel_latency", lat, 32'd33);
    chk("after_cancel_result", res_data, 32'd3);
    consume();

    // Cancel together with a request in IDLE must not accept
    req_valid = 1'b1;
    req_src1  = 32'd50;
    req_src2  = 32'd5;
    cancel    = 1'b1;
    #1;
    chk("idle_cancel_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cancel    = 1'b0;
    chk("idle_cancel_no_accept", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Result held while EX stalls
    start_req(1'b0, 1'b1, 32'd100, 32'd7);
    wait_result(lat);
    chk("hold_latency", lat, 32'd33);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_data_%0d", k), res_data, 32'd2);
      chk($sformatf("hold_valid_%0d", k), {31'd0, res_valid}, 32'd1);
      chk($sformatf("hold_req_ready_%0d", k), {31'd0, req_ready}, 32'd0);
    end
    consume();

    // Asynchronous reset in the middle of RUN
    start_req(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_res_data", res_data, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | res_valid;
    end
    chk("arst_no_result", {31'd0, seen}, 32'd0);

    // Normal operation afterwards
    start_req(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE);
    wait_result(lat);
    chk("post_arst_latency", lat, 32'd33);
    chk("post_arst_result", res_data, 32'd1);
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
